soc_arbiter_bb: RTL and testbench



---
 rtl/soc_arbiter_bb_if.sv | 30 +++
 rtl/soc_arbiter_bb.sv | 119 +++++++++++
 tb/tb_soc_arbiter_bb.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_arbiter_bb_if.sv
// rtl/soc_arbiter_bb_if.sv - master-side request bundle and shared slave bus for soc_arbiter_bb
interface soc_arbiter_bb_if #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_din_i;
    logic [MASTERS-1:0]                 m_en_i;
    logic [MASTERS-1:0]                 m_we_i;
    logic [MASTERS-1:0]                 m_lock_i;
    logic [MASTERS-1:0]                 m_stall_o;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dout_o;
    logic [MASTERS-1:0]                 m_rvalid_o;
    logic [ADDR_WIDTH-1:0]              s_addr_o;
    logic [DATA_WIDTH-1:0]              s_din_o;
    logic                               s_en_o;
    logic                               s_we_o;
    logic [DATA_WIDTH-1:0]              s_dout_i;

    modport master (
        output m_addr_i, m_din_i, m_en_i, m_we_i, m_lock_i, s_dout_i,
        input  m_stall_o, m_dout_o, m_rvalid_o, s_addr_o, s_din_o, s_en_o, s_we_o
    );

    modport slave (
        input  m_addr_i, m_din_i, m_en_i, m_we_i, m_lock_i, s_dout_i,
        output m_stall_o, m_dout_o, m_rvalid_o, s_addr_o, s_din_o, s_en_o, s_we_o
    );
endinterface

// File: rtl/soc_arbiter_bb.sv
// rtl/soc_arbiter_bb.sv - round-robin Blackbone arbiter with lock and one-cycle read return
module soc_arbiter_bb #(
    parameter int MASTERS     = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LOCK_ENABLE = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    soc_arbiter_bb_if.slave bus
);
    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t             state, state_next;
    logic [PW-1:0]      ptr, ptr_next;
    logic [PW-1:0]      owner, owner_next;
    logic [PW-1:0]      gidx;
    logic [CW-1:0]      cand;
    logic [MASTERS-1:0] grant;
    logic [MASTERS-1:0] rd_pend;
    logic               found;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
        return (k == PW'(MASTERS - 1)) ? '0 : k + 1'b1;
    endfunction

    always_comb begin
        grant      = '0;
        gidx       = '0;
        found      = 1'b0;
        cand       = '0;
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;

        if (state == LOCKED) begin
            if (bus.m_en_i[owner]) begin
                grant[owner] = 1'b1;
                gidx         = owner;
                found        = 1'b1;
            end
        end else begin
            // Scan from ptr upward with wrap; first requester wins.
            for (int i = 0; i < MASTERS; i++) begin
                cand = {1'b0, ptr} + CW'(i);
                if (cand >= CW'(MASTERS))
                    cand = cand - CW'(MASTERS);
                if (!found && bus.m_en_i[cand[PW-1:0]]) begin
                    grant[cand[PW-1:0]] = 1'b1;
                    gidx                = cand[PW-1:0];
                    found               = 1'b1;
                end
            end
        end

        case (state)
            ARB: begin
                if (found) begin
                    ptr_next = wrap_inc(gidx);
                    if (LOCK_ENABLE != 0 && bus.m_lock_i[gidx]) begin
                        state_next = LOCKED;
                        owner_next = gidx;
                    end
                end
            end
            LOCKED: begin
                // Dropping the lock bit releases even when the owner is idle.
                if (!bus.m_lock_i[owner]) begin
                    state_next = ARB;
                    if (found)
                        ptr_next = wrap_inc(owner);
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            rd_pend <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            owner   <= owner_next;
            rd_pend <= grant & ~{MASTERS{bus.s_we_o}};
        end
    end

    always_comb begin
        bus.s_addr_o = '0;
        bus.s_din_o  = '0;
        bus.s_we_o   = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant[i]) begin
                bus.s_addr_o = bus.s_addr_o | bus.m_addr_i[i];
                bus.s_din_o  = bus.s_din_o | bus.m_din_i[i];
                bus.s_we_o   = bus.s_we_o | bus.m_we_i[i];
            end
        end
    end

    assign bus.s_en_o     = |grant;
    assign bus.m_stall_o  = bus.m_en_i & ~grant;
    assign bus.m_rvalid_o = rd_pend;

    always_comb begin
        bus.m_dout_o = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (rd_pend[i])
                bus.m_dout_o[i] = bus.s_dout_i;
        end
    end
endmodule

// File: tb/tb_soc_arbiter_bb.sv
// tb/tb_soc_arbiter_bb.sv - directed and random checks of soc_arbiter_bb against a reference model
module tb_soc_arbiter_bb;
    localparam int M  = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soc_arbiter_bb_if #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    soc_arbiter_bb_if #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    soc_arbiter_bb #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_ENABLE(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a));
    soc_arbiter_bb #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_ENABLE(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b));

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]    en, we, lock;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];

    logic [31:0] mem     [2][256];
    logic [31:0] mem_ref [2][256];
    int          rd_idx  [2];

    int          mptr [2];
    int          mowner [2];
    int          mpend [2];
    bit          mlocked [2];
    logic [31:0] mpdata [2];

    logic [1:0]  o_stall [2];
    logic [1:0]  o_rvalid [2];
    logic        o_sen [2];
    logic        o_swe [2];
    logic [31:0] o_saddr [2];
    logic [31:0] o_sdin [2];
    logic [63:0] o_dout [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mptr[d] = 0; mowner[d] = 0; mpend[d] = -1; mlocked[d] = 0; rd_idx[d] = -1;
        end
    endtask

    task automatic apply();
        bus_a.m_en_i = en;  bus_a.m_we_i = we;  bus_a.m_lock_i = lock;
        bus_b.m_en_i = en;  bus_b.m_we_i = we;  bus_b.m_lock_i = lock;
        bus_a.m_addr_i = {addr[1], addr[0]};  bus_a.m_din_i = {din[1], din[0]};
        bus_b.m_addr_i = {addr[1], addr[0]};  bus_b.m_din_i = {din[1], din[0]};
        bus_a.s_dout_i = (rd_idx[0] >= 0) ? mem[0][rd_idx[0]] : $urandom();
        bus_b.s_dout_i = (rd_idx[1] >= 0) ? mem[1][rd_idx[1]] : $urandom();
    endtask

    task automatic sample();
        o_stall[0] = bus_a.m_stall_o;  o_stall[1] = bus_b.m_stall_o;
        o_rvalid[0] = bus_a.m_rvalid_o; o_rvalid[1] = bus_b.m_rvalid_o;
        o_sen[0] = bus_a.s_en_o;  o_sen[1] = bus_b.s_en_o;
        o_swe[0] = bus_a.s_we_o;  o_swe[1] = bus_b.s_we_o;
        o_saddr[0] = bus_a.s_addr_o;  o_saddr[1] = bus_b.s_addr_o;
        o_sdin[0] = bus_a.s_din_o;  o_sdin[1] = bus_b.s_din_o;
        o_dout[0] = bus_a.m_dout_o;  o_dout[1] = bus_b.m_dout_o;
    endtask

    task automatic model_step(input int d);
        int g;
        logic [1:0] gv, exp_rv;
        logic [63:0] exp_dout;
        int idx;
        string nm;
        nm = (d == 0) ? "a" : "b";
        g = -1;
        if (mlocked[d]) begin
            if (en[mowner[d]]) g = mowner[d];
        end else begin
            for (int k = 0; k < M; k++) begin
                int j;
                j = (mptr[d] + k) % M;
                if (g < 0 && en[j]) g = j;
            end
        end
        gv = (g >= 0) ? 2'(1 << g) : 2'b00;
        exp_rv = (mpend[d] >= 0) ? 2'(1 << mpend[d]) : 2'b00;
        exp_dout = '0;
        if (mpend[d] >= 0) exp_dout[mpend[d]*32 +: 32] = mpdata[d];
        chk({nm, ".stall"},  64'(o_stall[d]),  64'(en & ~gv));
        chk({nm, ".s_en"},   64'(o_sen[d]),    64'(g >= 0));
        chk({nm, ".s_addr"}, 64'(o_saddr[d]),  (g >= 0) ? 64'(addr[g]) : 64'd0);
        chk({nm, ".s_we"},   64'(o_swe[d]),    (g >= 0) ? 64'(we[g]) : 64'd0);
        chk({nm, ".s_din"},  64'(o_sdin[d]),   (g >= 0) ? 64'(din[g]) : 64'd0);
        chk({nm, ".rvalid"}, 64'(o_rvalid[d]), 64'(exp_rv));
        chk({nm, ".dout"},   o_dout[d],        exp_dout);

        mpend[d] = -1;
        if (g >= 0) begin
            idx = int'(addr[g][9:2]);
            if (we[g]) mem_ref[d][idx] = din[g];
            else begin mpend[d] = g; mpdata[d] = mem_ref[d][idx]; end
        end
        if (mlocked[d]) begin
            if (!lock[mowner[d]]) begin
                mlocked[d] = 0;
                if (g >= 0) mptr[d] = (mowner[d] + 1) % M;
            end
        end else if (g >= 0) begin
            mptr[d] = (g + 1) % M;
            if (d == 0 && lock[g]) begin mlocked[d] = 1; mowner[d] = g; end
        end
    endtask

    // One bus cycle: drive at the falling edge, check 1 ns later, respond as the slave memory.
    task automatic cycle();
        apply();
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            rd_idx[d] = -1;
            if (o_sen[d]) begin
                if (o_swe[d]) mem[d][o_saddr[d][9:2]] = o_sdin[d];
                else rd_idx[d] = int'(o_saddr[d][9:2]);
            end
            model_step(d);
        end
        @(negedge clk);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        en = 2'b00; we = 2'b00; lock = 2'b00;
        apply();
        #1;
        sample();
        chk("rst.a.s_en", 64'(o_sen[0]), 64'd0);
        chk("rst.a.rvalid", 64'(o_rvalid[0]), 64'd0);
        chk("rst.a.dout", o_dout[0], 64'd0);
        chk("rst.b.rvalid", 64'(o_rvalid[1]), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mid_reset(input logic [1:0] rv_before);
        en = 2'b00;
        apply();
        #1;
        sample();
        chk("mid.a.rvalid_before", 64'(o_rvalid[0]), 64'(rv_before));
        rst = 1'b1;
        #1;
        sample();
        chk("mid.a.rvalid_after", 64'(o_rvalid[0]), 64'd0);
        chk("mid.a.dout_after", o_dout[0], 64'd0);
        chk("mid.b.rvalid_after", 64'(o_rvalid[1]), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_m(input int i, input logic [AW-1:0] a, input logic [DW-1:0] dv);
        addr[i] = a;
        din[i]  = dv;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                logic [31:0] v;
                v = $urandom();
                mem[d][i] = v;
                mem_ref[d][i] = v;
            end
            mem[d][64] = 32'hAAAA;  mem_ref[d][64] = 32'hAAAA;
            mem[d][128] = 32'hBBBB; mem_ref[d][128] = 32'hBBBB;
        end
        set_m(0, '0, '0);
        set_m(1, '0, '0);
        hard_reset();

        // Simultaneous reads, pipelined return
        en = 2'b11; we = 2'b00; lock = 2'b00;
        set_m(0, 32'h100, $urandom()); set_m(1, 32'h200, $urandom());
        cycle();
        chk("t1.c0.s_addr", 64'(o_saddr[0]), 64'h100);
        chk("t1.c0.stall", 64'(o_stall[0]), 64'b10);
        en = 2'b10;
        cycle();
        chk("t1.c1.s_addr", 64'(o_saddr[0]), 64'h200);
        chk("t1.c1.rvalid", 64'(o_rvalid[0]), 64'b01);
        chk("t1.c1.dout0", 64'(o_dout[0][31:0]), 64'hAAAA);
        en = 2'b00;
        cycle();
        chk("t1.c2.rvalid", 64'(o_rvalid[0]), 64'b10);
        chk("t1.c2.dout1", 64'(o_dout[0][63:32]), 64'hBBBB);

        // Continuous writes alternate
        en = 2'b11; we = 2'b11;
        for (int i = 0; i < 6; i++) begin
            set_m(0, {22'd0, 8'($urandom()), 2'b00}, $urandom());
            set_m(1, {22'd0, 8'($urandom()), 2'b00}, $urandom());
            cycle();
            chk("t2.stall", 64'(o_stall[0]), (i % 2 == 0) ? 64'b10 : 64'b01);
            chk("t2.rvalid", 64'(o_rvalid[0]), 64'd0);
        end

        // Locked sequence from m1 blocks m0
        en = 2'b01; we = 2'b01; lock = 2'b00;
        cycle();
        for (int i = 0; i < 4; i++) begin
            en = 2'b11; we = 2'b11;
            lock = (i < 3) ? 2'b10 : 2'b00;
            set_m(1, {22'd0, 8'($urandom()), 2'b00}, $urandom());
            cycle();
            chk("t3.m0_stalled", 64'(o_stall[0]), 64'b01);
        end
        lock = 2'b00;
        cycle();
        chk("t3.m0_granted", 64'(o_stall[0]), 64'b10);

        // Lone m1 request with ptr=0 wraps ptr back to 0
        en = 2'b10; we = 2'b10;
        cycle();
        cycle();
        chk("t4.stall", 64'(o_stall[0]), 64'b00);
        chk("t4.s_en", 64'(o_sen[0]), 64'd1);
        en = 2'b11;
        cycle();
        chk("t4.ptr0", 64'(o_stall[0]), 64'b10);

        // Reset with a read pending and lock held
        en = 2'b01; we = 2'b00; lock = 2'b01;
        set_m(0, {22'd0, 8'($urandom()), 2'b00}, $urandom());
        cycle();
        mid_reset(2'b01);
        en = 2'b10; we = 2'b10; lock = 2'b01;
        cycle();
        chk("t5.unlocked", 64'(o_stall[0]), 64'b00);
        en = 2'b01; we = 2'b01; lock = 2'b00;
        cycle();
        mid_reset(2'b00);
        en = 2'b11; we = 2'b11;
        cycle();
        chk("t5.ptr0", 64'(o_stall[0]), 64'b10);

        // Lock ignored when disabled
        hard_reset();
        en = 2'b11; we = 2'b11; lock = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6.b.stall", 64'(o_stall[1]), (i % 2 == 0) ? 64'b10 : 64'b01);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            en   = 2'($urandom());
            we   = 2'($urandom());
            lock = 2'($urandom() & $urandom());
            for (int i = 0; i < 2; i++)
                set_m(i, {22'd0, 8'($urandom()), 2'b00}, $urandom());
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
